// File: rtl/wordseq_pkg.sv
// wordseq_pkg: shared types and constants for the word sequencer.
//   state_t        - sequencer FSM states (ST_SEP exists only when
//                    WORDSEQ_SEP_EN is defined)
//   ROM constants  - the four ASCII words and their length table
//   find_set_bit() - lowest set bit of a mask at or above a start index
package wordseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_NEXT  = 3'd5,
    ST_GAP   = 3'd6
`ifdef WORDSEQ_SEP_EN
    , ST_SEP = 3'd7
`endif
  } state_t;

  localparam int ROM_WORDS     = 4;
  localparam int ROM_STR_BYTES = 16;

  typedef logic [8*ROM_STR_BYTES-1:0] rom_str_t;

  // Strings are right-justified: the first character sits in the highest
  // occupied byte, the last character in bits [7:0].
  localparam rom_str_t WORD0_STR = {40'h0, "HELLO WORLD"};
  localparam rom_str_t WORD1_STR = {48'h0, "FPGA BOARD"};
  localparam rom_str_t WORD2_STR = {72'h0, "VERILOG"};
  localparam rom_str_t WORD3_STR = {96'h0, "DONE"};

  localparam int WORD_LEN_TABLE [ROM_WORDS] = '{11, 10, 7, 4};

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } bit_hit_t;

  // Scanning downward lets the last hit win, which yields the lowest set
  // bit whose index is >= first.
  function automatic bit_hit_t find_set_bit(input logic [15:0] mask, input int first);
    bit_hit_t hit;
    hit = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (i >= first)) begin
        hit.found = 1'b1;
        hit.idx   = 4'(i);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/word_rom.sv
// word_rom: combinational character ROM for the word sequencer.
//   word_idx  in  - word index
//   char_idx  in  - character index within the word
//   char_byte out - ASCII byte; 8'h00 when char_idx is past the word end
//   word_len  out - length of the selected word (1 for unpopulated words)
module word_rom
  import wordseq_pkg::*;
#(
  parameter  int NUM_WORDS = 4,
  parameter  int MAX_LEN   = 16,
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic [WW-1:0] word_idx,
  input  logic [CW-1:0] char_idx,
  output logic [7:0]    char_byte,
  output logic [LW-1:0] word_len
);

  rom_str_t str;
  int       len;

  always_comb begin
    str = '0;
    len = 1;
    case (int'(word_idx))
      0: begin str = WORD0_STR; len = WORD_LEN_TABLE[0]; end
      1: begin str = WORD1_STR; len = WORD_LEN_TABLE[1]; end
      2: begin str = WORD2_STR; len = WORD_LEN_TABLE[2]; end
      3: begin str = WORD3_STR; len = WORD_LEN_TABLE[3]; end
      default: ;
    endcase
    char_byte = 8'h00;
    if (int'(char_idx) < len) begin
      char_byte = str[8*(len - 1 - int'(char_idx)) +: 8];
    end
    word_len = LW'(len);
  end

endmodule

// File: rtl/word_sequencer.sv
// word_sequencer: streams ROM words byte-by-byte into a serializer over a
// start/busy handshake, single-shot or auto-repeat with an inter-pass gap.
//   sysclk, rst_n  - clock, asynchronous active-low reset
//   word_en        - per-word enable mask
//   write_pulse    - request one pass (ignored while busy)
//   auto_toggle    - flip auto-repeat mode
//   tx_busy        - serializer busy
//   tx_data/tx_start - byte and one-cycle strobe to the serializer
//   auto_on, busy, cur_word - status
// Optional feature: define WORDSEQ_SEP_EN to send SEP_BYTE after each word.
module word_sequencer
  import wordseq_pkg::*;
#(
  parameter  int          NUM_WORDS  = 4,
  parameter  int          MAX_LEN    = 16,
  parameter  int          GAP_CYCLES = 25_000_000,
`ifdef WORDSEQ_SEP_EN
  parameter  logic [7:0]  SEP_BYTE   = 8'h20,
`endif
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int GW = $clog2(GAP_CYCLES + 1)
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [NUM_WORDS-1:0] word_en,
  input  logic                 write_pulse,
  input  logic                 auto_toggle,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 auto_on,
  output logic                 busy,
  output logic [WW-1:0]        cur_word
);

  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] char_q, char_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          auto_q, auto_d;
  logic          busy_q, busy_d;
  logic [WW-1:0] cur_word_q, cur_word_d;
`ifdef WORDSEQ_SEP_EN
  logic          sep_q, sep_d;
`endif

  logic [7:0]    rom_byte;
  logic [LW-1:0] rom_len;
  logic [15:0]   mask16;
  bit_hit_t      first_hit, above_hit;
  logic          mask_any, last_char, start_req, gap_done;

  word_rom #(
    .NUM_WORDS (NUM_WORDS),
    .MAX_LEN   (MAX_LEN)
  ) u_rom (
    .word_idx  (cur_word_q),
    .char_idx  (char_q),
    .char_byte (rom_byte),
    .word_len  (rom_len)
  );

  assign mask16    = 16'(word_en);
  assign first_hit = find_set_bit(mask16, 0);
  assign above_hit = find_set_bit(mask16, int'(cur_word_q) + 1);
  assign mask_any  = |word_en;
  assign last_char = (LW'(char_q) == (rom_len - LW'(1)));
  // Auto mode re-arms from IDLE on its own; an empty mask drops the request.
  assign start_req = (write_pulse || auto_q) && mask_any;
  assign gap_done  = (gap_q == GAP_LAST);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_req) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SEND;
      ST_SEND:  if (!tx_busy) state_d = ST_ACK;
      ST_ACK:   if (tx_busy) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!tx_busy) begin
`ifdef WORDSEQ_SEP_EN
          if (sep_q)          state_d = ST_NEXT;
          else if (last_char) state_d = ST_SEP;
          else                state_d = ST_SEND;
`else
          state_d = last_char ? ST_NEXT : ST_SEND;
`endif
        end
      end
`ifdef WORDSEQ_SEP_EN
      ST_SEP:   if (!tx_busy) state_d = ST_ACK;
`endif
      ST_NEXT: begin
        if (above_hit.found) state_d = ST_LOAD;
        else if (auto_q)     state_d = ST_GAP;
        else                 state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (!auto_q)       state_d = ST_IDLE;
        else if (gap_done) state_d = mask_any ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered so the
  // serializer sees glitch-free strobes.
  always_comb begin
    char_d     = char_q;
    gap_d      = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    cur_word_d = cur_word_q;
    auto_d     = auto_q ^ auto_toggle;
    busy_d     = (state_d != ST_IDLE);
`ifdef WORDSEQ_SEP_EN
    sep_d      = sep_q;
`endif
    case (state_q)
      ST_IDLE: if (start_req) cur_word_d = WW'(first_hit.idx);
      ST_LOAD: char_d = '0;
      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = rom_byte;
          tx_start_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
`ifdef WORDSEQ_SEP_EN
          if (sep_q)           sep_d  = 1'b0;
          else if (!last_char) char_d = char_q + CW'(1);
`else
          if (!last_char) char_d = char_q + CW'(1);
`endif
        end
      end
`ifdef WORDSEQ_SEP_EN
      ST_SEP: begin
        if (!tx_busy) begin
          tx_data_d  = SEP_BYTE;
          tx_start_d = 1'b1;
          sep_d      = 1'b1;
        end
      end
`endif
      ST_NEXT: if (above_hit.found) cur_word_d = WW'(above_hit.idx);
      ST_GAP: begin
        // Counter holds at its terminal value rather than wrapping.
        if (auto_q) begin
          if (gap_done) begin
            gap_d = gap_q;
            if (mask_any) cur_word_d = WW'(first_hit.idx);
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      char_q     <= '0;
      gap_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      auto_q     <= 1'b0;
      busy_q     <= 1'b0;
      cur_word_q <= '0;
`ifdef WORDSEQ_SEP_EN
      sep_q      <= 1'b0;
`endif
    end else begin
      char_q     <= char_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      auto_q     <= auto_d;
      busy_q     <= busy_d;
      cur_word_q <= cur_word_d;
`ifdef WORDSEQ_SEP_EN
      sep_q      <= sep_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign auto_on  = auto_q;
  assign busy     = busy_q;
  assign cur_word = cur_word_q;

endmodule

// File: tb/tb_word_sequencer.sv
// tb_word_sequencer: directed self-checking bench for word_sequencer with a
// 3-cycle-busy serializer model. Honours WORDSEQ_SEP_EN when defined.
module tb_word_sequencer;

  localparam int NUM_WORDS  = 4;
  localparam int MAX_LEN    = 16;
  localparam int GAP_CYCLES = 20;
`ifdef WORDSEQ_SEP_EN
  localparam int SEP_N = 1;
`else
  localparam int SEP_N = 0;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] word_en = 4'b0000;
  logic       write_pulse = 1'b0;
  logic       auto_toggle = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       auto_on;
  logic       busy;
  logic [1:0] cur_word;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ser_cnt = 0;
  bit ser_stall = 1'b0;
  int pulse_cyc = 0;
  int toggle_cyc = 0;

  logic [7:0] got_bytes[$];
  int         got_words[$];
  int         got_cyc[$];
  logic [7:0] exp_bytes[$];
  int         exp_words[$];

  word_sequencer #(
    .NUM_WORDS  (NUM_WORDS),
    .MAX_LEN    (MAX_LEN),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .word_en     (word_en),
    .write_pulse (write_pulse),
    .auto_toggle (auto_toggle),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .auto_on     (auto_on),
    .busy        (busy),
    .cur_word    (cur_word)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc = cyc + 1;

  // Capture each strobe and emulate a serializer busy for 3 cycles.
  always @(negedge sysclk) begin
    if (tx_start === 1'b1) begin
      got_bytes.push_back(tx_data);
      got_words.push_back(int'(cur_word));
      got_cyc.push_back(cyc);
    end
    if (tx_start === 1'b1) ser_cnt = 3;
    else if (ser_cnt > 0) ser_cnt = ser_cnt - 1;
    tx_busy = (ser_cnt > 0) && !ser_stall;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_capture();
    got_bytes.delete(); got_words.delete(); got_cyc.delete();
    exp_bytes.delete(); exp_words.delete();
  endtask

  task automatic add_word(input string s, input int w);
    for (int i = 0; i < s.len(); i++) begin
      exp_bytes.push_back(s[i]);
      exp_words.push_back(w);
    end
`ifdef WORDSEQ_SEP_EN
    exp_bytes.push_back(8'h20);
    exp_words.push_back(w);
`endif
  endtask

  task automatic pulse_write();
    @(negedge sysclk); write_pulse = 1'b1; pulse_cyc = cyc;
    @(negedge sysclk); write_pulse = 1'b0;
  endtask

  task automatic pulse_toggle();
    @(negedge sysclk); auto_toggle = 1'b1; toggle_cyc = cyc;
    @(negedge sysclk); auto_toggle = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sysclk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sysclk);
      if (got_bytes.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sysclk);
    n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (tx_start !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_tx_start: got %b want 0", tx_start); end
    n_checks++; if (auto_on !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_auto_on: got %b want 0", auto_on); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (cur_word !== 2'd0) begin n_errors++; $display("[TB] FAIL reset_cur_word: got %0d want 0", cur_word); end
    @(negedge sysclk); rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic test_single_pass();
    bit ok;
    clear_capture();
    word_en = 4'b0001;
    add_word("HELLO WORLD", 0);
    pulse_write();
    wait_idle(400, ok);
    repeat (10) @(negedge sysclk);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL single_timeout: busy still %b, want 0", busy); end
    n_checks++; if (got_bytes.size() != exp_bytes.size()) begin n_errors++; $display("[TB] FAIL single_count: got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i]) begin n_errors++; $display("[TB] FAIL single_byte[%0d]: got %h want %h", i, got_bytes[i], exp_bytes[i]); end
    end
    if (got_cyc.size() >= 2) begin
      n_checks++; if (got_cyc[0] - pulse_cyc != 3) begin n_errors++; $display("[TB] FAIL single_latency: got %0d want 3", got_cyc[0] - pulse_cyc); end
      n_checks++; if (got_cyc[1] - got_cyc[0] != 5) begin n_errors++; $display("[TB] FAIL single_spacing: got %0d want 5", got_cyc[1] - got_cyc[0]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL single_busy_end: got %b want 0", busy); end
    n_checks++; if (cur_word !== 2'd0) begin n_errors++; $display("[TB] FAIL single_cur_word: got %0d want 0", cur_word); end
  endtask

  task automatic test_masked_pass();
    bit ok;
    clear_capture();
    word_en = 4'b1010;
    add_word("FPGA BOARD", 1);
    add_word("DONE", 3);
    pulse_write();
    wait_idle(600, ok);
    repeat (10) @(negedge sysclk);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL masked_timeout: busy still %b, want 0", busy); end
    n_checks++; if (got_bytes.size() != exp_bytes.size()) begin n_errors++; $display("[TB] FAIL masked_count: got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i] || got_words[i] != exp_words[i]) begin
        n_errors++;
        $display("[TB] FAIL masked_byte[%0d]: got %h/word %0d want %h/word %0d", i, got_bytes[i], got_words[i], exp_bytes[i], exp_words[i]);
      end
    end
    n_checks++; if (cur_word !== 2'd3) begin n_errors++; $display("[TB] FAIL masked_cur_word: got %0d want 3", cur_word); end
  endtask

  task automatic test_auto_mode();
    bit ok;
    int on_cyc;
    int len;
    len = 7 + SEP_N;
    clear_capture();
    word_en = 4'b0100;
    for (int p = 0; p < 3; p++) add_word("VERILOG", 2);
    pulse_toggle();
    on_cyc = toggle_cyc;
    n_checks++; if (auto_on !== 1'b1) begin n_errors++; $display("[TB] FAIL auto_on_set: got %b want 1", auto_on); end
    wait_bytes(2*len + 2, 600, ok);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL auto_progress: got %0d bytes want %0d", got_bytes.size(), 2*len + 2); end
    pulse_toggle();
    n_checks++; if (auto_on !== 1'b0) begin n_errors++; $display("[TB] FAIL auto_on_clear: got %b want 0", auto_on); end
    wait_idle(400, ok);
    repeat (40) @(negedge sysclk);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL auto_idle_timeout: busy still %b, want 0", busy); end
    n_checks++; if (got_bytes.size() != exp_bytes.size()) begin n_errors++; $display("[TB] FAIL auto_count: got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i]) begin n_errors++; $display("[TB] FAIL auto_byte[%0d]: got %h want %h", i, got_bytes[i], exp_bytes[i]); end
    end
    if (got_cyc.size() > 2*len) begin
      n_checks++; if (got_cyc[0] - on_cyc != 4) begin n_errors++; $display("[TB] FAIL auto_start_latency: got %0d want 4", got_cyc[0] - on_cyc); end
      n_checks++; if (got_cyc[len] - got_cyc[len-1] != GAP_CYCLES + 7) begin n_errors++; $display("[TB] FAIL auto_gap1: got %0d want %0d", got_cyc[len] - got_cyc[len-1], GAP_CYCLES + 7); end
      n_checks++; if (got_cyc[2*len] - got_cyc[2*len-1] != GAP_CYCLES + 7) begin n_errors++; $display("[TB] FAIL auto_gap2: got %0d want %0d", got_cyc[2*len] - got_cyc[2*len-1], GAP_CYCLES + 7); end
    end
    n_checks++; if (cur_word !== 2'd2) begin n_errors++; $display("[TB] FAIL auto_cur_word: got %0d want 2", cur_word); end
  endtask

  task automatic test_empty_and_busy();
    bit ok;
    clear_capture();
    word_en = 4'b0000;
    pulse_write();
    repeat (10) @(negedge sysclk);
    n_checks++; if (got_bytes.size() != 0) begin n_errors++; $display("[TB] FAIL empty_strobes: got %0d want 0", got_bytes.size()); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL empty_busy: got %b want 0", busy); end
    word_en = 4'b1000;
    add_word("DONE", 3);
    pulse_write();
    // Second request lands while the sequencer sits in SEND.
    @(negedge sysclk); write_pulse = 1'b1;
    @(negedge sysclk); write_pulse = 1'b0;
    wait_idle(300, ok);
    repeat (15) @(negedge sysclk);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL busyreq_timeout: busy still %b, want 0", busy); end
    n_checks++; if (got_bytes.size() != exp_bytes.size()) begin n_errors++; $display("[TB] FAIL busyreq_count: got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i]) begin n_errors++; $display("[TB] FAIL busyreq_byte[%0d]: got %h want %h", i, got_bytes[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_capture();
    word_en = 4'b0010;
    ser_stall = 1'b1;
    pulse_toggle();
    wait_bytes(1, 50, ok);
    repeat (2) @(negedge sysclk);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL rstmid_first_byte: got %0d bytes want 1", got_bytes.size()); end
    n_checks++; if (tx_data !== 8'h46 || busy !== 1'b1 || auto_on !== 1'b1) begin
      n_errors++; $display("[TB] FAIL rstmid_pre: got data %h busy %b auto %b want 46 1 1", tx_data, busy, auto_on);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("[TB] FAIL rstmid_tx_data: got %h want 00", tx_data); end
    n_checks++; if (auto_on !== 1'b0) begin n_errors++; $display("[TB] FAIL rstmid_auto_on: got %b want 0", auto_on); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (cur_word !== 2'd0) begin n_errors++; $display("[TB] FAIL rstmid_cur_word: got %0d want 0", cur_word); end
    n_checks++; if (tx_start !== 1'b0) begin n_errors++; $display("[TB] FAIL rstmid_tx_start: got %b want 0", tx_start); end
    ser_stall = 1'b0;
    @(negedge sysclk); rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
    clear_capture();
    add_word("FPGA BOARD", 1);
    pulse_write();
    wait_idle(400, ok);
    repeat (10) @(negedge sysclk);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL rstmid_timeout: busy still %b, want 0", busy); end
    n_checks++; if (got_bytes.size() != exp_bytes.size()) begin n_errors++; $display("[TB] FAIL rstmid_count: got %0d want %0d", got_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i]) begin n_errors++; $display("[TB] FAIL rstmid_byte[%0d]: got %h want %h", i, got_bytes[i], exp_bytes[i]); end
    end
  endtask

`ifdef WORDSEQ_SEP_EN
  task automatic test_separator();
    bit ok;
    clear_capture();
    word_en = 4'b1000;
    pulse_write();
    wait_idle(300, ok);
    repeat (10) @(negedge sysclk);
    n_checks++; if (!ok) begin n_errors++; $display("[TB] FAIL sep_timeout: busy still %b, want 0", busy); end
    n_checks++; if (got_bytes.size() != 5) begin n_errors++; $display("[TB] FAIL sep_count: got %0d want 5", got_bytes.size()); end
    if (got_bytes.size() == 5) begin
      n_checks++; if (got_bytes[3] !== 8'h45) begin n_errors++; $display("[TB] FAIL sep_last_char: got %h want 45", got_bytes[3]); end
      n_checks++; if (got_bytes[4] !== 8'h20) begin n_errors++; $display("[TB] FAIL sep_byte: got %h want 20", got_bytes[4]); end
    end
  endtask
`endif

  initial begin
    $display("[TB] word_sequencer bench start");
    test_reset();
    test_single_pass();
    test_masked_pass();
    test_auto_mode();
    test_empty_and_busy();
    test_reset_mid();
`ifdef WORDSEQ_SEP_EN
    test_separator();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
